// File: rtl/sent_rx_pkg.sv
// Shared definitions for the SENT receive CRC checker: mode encodings,
// CRC polynomials/seeds, field geometry lookup and the checker FSM states.
package sent_rx_pkg;

  // Mode encodings, identical to the ones used by the TX CRC generator
  typedef enum logic [2:0] {
    MODE_NONE  = 3'b000,
    MODE_FAST6 = 3'b001,
    MODE_FAST4 = 3'b010,
    MODE_FAST3 = 3'b011,
    MODE_SHORT = 3'b100,
    MODE_ENH   = 3'b101
  } sent_mode_e;

  // CRC-4: x^4+x^3+x^2+1, CRC-6: x^6+x^4+x^3+1 (feedback taps without x^W)
  localparam logic [3:0] CRC4_POLY = 4'b1101;
  localparam logic [3:0] CRC4_SEED = 4'b0101;
  localparam logic [5:0] CRC6_POLY = 6'b011001;
  localparam logic [5:0] CRC6_SEED = 6'b010101;

  // Remaining augmentation bits minus one for each CRC width
  localparam logic [4:0] CRC4_AUG_M1 = 5'd3;
  localparam logic [4:0] CRC6_AUG_M1 = 5'd5;

  // Geometry of one check: valid mode, CRC-6 select, field length minus one
  typedef struct packed {
    logic       valid;
    logic       wide;
    logic [4:0] lenM1;
  } mode_cfg_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_AUG,
    ST_CHECK
  } chk_state_e;

  function automatic mode_cfg_t modeLookup(input logic [2:0] mode);
    mode_cfg_t cfg;
    cfg = '{valid: 1'b0, wide: 1'b0, lenM1: 5'd0};
    case (mode)
      MODE_FAST6: cfg = '{valid: 1'b1, wide: 1'b0, lenM1: 5'd23};
      MODE_FAST4: cfg = '{valid: 1'b1, wide: 1'b0, lenM1: 5'd15};
      MODE_FAST3: cfg = '{valid: 1'b1, wide: 1'b0, lenM1: 5'd11};
      MODE_SHORT: cfg = '{valid: 1'b1, wide: 1'b0, lenM1: 5'd11};
      MODE_ENH:   cfg = '{valid: 1'b1, wide: 1'b1, lenM1: 5'd23};
      default:    cfg = '{valid: 1'b0, wide: 1'b0, lenM1: 5'd0};
    endcase
    return cfg;
  endfunction

endpackage

// File: rtl/sent_crc_lfsr_step.sv
// One bit of augmented CRC division: shift the message bit in at the LSB
// and fold the polynomial back in whenever the outgoing MSB is set.
module sent_crc_lfsr_step #(
  parameter int           W        = 4,
  parameter logic [W-1:0] FEEDBACK = '0
) (
  input  logic [W-1:0] r_i,
  input  logic         bit_i,
  output logic [W-1:0] r_o
);

  // Pure combinational step so the top can pick either width per cycle
  always_comb begin
    r_o = {r_i[W-2:0], bit_i} ^ (r_i[W-1] ? FEEDBACK : {W{1'b0}});
  end

endmodule

// File: rtl/sent_rx_crc_chk.sv
// SENT receive CRC checker: recomputes the CRC-4/CRC-6 of a captured
// fast-channel nibble group or serial message bit by bit, compares it with
// the received CRC and keeps a saturating count of mismatches.
module sent_rx_crc_chk #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_rx,
  input  logic                 reset_n_rx,
  input  logic [2:0]           enable_crc_chk_i,
  input  logic                 start_i,
  input  logic [23:0]          data_chk_crc_i,
  input  logic [5:0]           crc_rx_i,
  output logic                 busy_o,
  output logic                 crc_chk_done_o,
  output logic                 crc_ok_o,
  output logic [5:0]           crc_calc_o,
  output logic [ERR_CNT_W-1:0] crc_err_cnt_o
);

  import sent_rx_pkg::*;

  localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  chk_state_e           state_q;
  logic [4:0]           cnt_q;
  logic [5:0]           r_q;
  logic [23:0]          data_q;
  logic [5:0]           crcRx_q;
  logic                 wide_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 ok_q;
  logic [5:0]           calc_q;
  logic [ERR_CNT_W-1:0] errCnt_q;

  mode_cfg_t            startCfg;
  logic                 feedBit;
  logic [3:0]           r4Step;
  logic [5:0]           r6Step;
  logic [5:0]           rStep_d;
  logic                 crcMatch;

  sent_crc_lfsr_step #(.W(4), .FEEDBACK(CRC4_POLY)) u_step4 (
    .r_i   (r_q[3:0]),
    .bit_i (feedBit),
    .r_o   (r4Step)
  );

  sent_crc_lfsr_step #(.W(6), .FEEDBACK(CRC6_POLY)) u_step6 (
    .r_i   (r_q),
    .bit_i (feedBit),
    .r_o   (r6Step)
  );

  // Message bits MSB first while shifting, zero bits during augmentation
  always_comb begin
    startCfg = modeLookup(enable_crc_chk_i);
    feedBit  = (state_q == ST_SHIFT) ? data_q[cnt_q] : 1'b0;
    rStep_d  = wide_q ? r6Step : {2'b00, r4Step};
    crcMatch = (r_q == crcRx_q);
  end

  // Checker FSM with all outputs registered; received CRC is masked at capture
  always_ff @(posedge clk_rx) begin
    if (!reset_n_rx) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 5'd0;
      r_q      <= 6'd0;
      data_q   <= 24'd0;
      crcRx_q  <= 6'd0;
      wide_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ok_q     <= 1'b0;
      calc_q   <= 6'd0;
      errCnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i && startCfg.valid) begin
            data_q  <= data_chk_crc_i;
            crcRx_q <= startCfg.wide ? crc_rx_i : {2'b00, crc_rx_i[3:0]};
            wide_q  <= startCfg.wide;
            r_q     <= startCfg.wide ? CRC6_SEED : {2'b00, CRC4_SEED};
            cnt_q   <= startCfg.lenM1;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_q <= rStep_d;
          if (cnt_q == 5'd0) begin
            cnt_q   <= wide_q ? CRC6_AUG_M1 : CRC4_AUG_M1;
            state_q <= ST_AUG;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        ST_AUG: begin
          r_q <= rStep_d;
          if (cnt_q == 5'd0) begin
            state_q <= ST_CHECK;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        ST_CHECK: begin
          calc_q  <= r_q;
          ok_q    <= crcMatch;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
          if (!crcMatch && (errCnt_q != {ERR_CNT_W{1'b1}})) begin
            errCnt_q <= errCnt_q + ERR_ONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign crc_chk_done_o = done_q;
  assign crc_ok_o       = ok_q;
  assign crc_calc_o     = calc_q;
  assign crc_err_cnt_o  = errCnt_q;

endmodule

// File: tb/tb_sent_rx_crc_chk.sv
// Self-checking bench for sent_rx_crc_chk: a polynomial-division reference
// model predicts every output each cycle, backed by directed literal cases.
module tb_sent_rx_crc_chk;

  localparam int ERR_W   = 8;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic             clk_rx = 1'b0;
  logic             reset_n_rx;
  logic [2:0]       enable_crc_chk_i;
  logic             start_i;
  logic [23:0]      data_chk_crc_i;
  logic [5:0]       crc_rx_i;
  logic             busy_o;
  logic             crc_chk_done_o;
  logic             crc_ok_o;
  logic [5:0]       crc_calc_o;
  logic [ERR_W-1:0] crc_err_cnt_o;

  int checks   = 0;
  int failures = 0;
  bit cmpEn    = 1'b0;

  // Reference model state
  bit       mBusy = 1'b0;
  bit       mDone = 1'b0;
  bit       mOk   = 1'b0;
  bit       pendOk;
  int       mRem  = 0;
  int       mErr  = 0;
  logic [5:0] mCalc = 6'd0;
  logic [5:0] pendCalc;

  sent_rx_crc_chk #(.ERR_CNT_W(ERR_W)) dut (
    .clk_rx           (clk_rx),
    .reset_n_rx       (reset_n_rx),
    .enable_crc_chk_i (enable_crc_chk_i),
    .start_i          (start_i),
    .data_chk_crc_i   (data_chk_crc_i),
    .crc_rx_i         (crc_rx_i),
    .busy_o           (busy_o),
    .crc_chk_done_o   (crc_chk_done_o),
    .crc_ok_o         (crc_ok_o),
    .crc_calc_o       (crc_calc_o),
    .crc_err_cnt_o    (crc_err_cnt_o)
  );

  always #5 clk_rx = ~clk_rx;

  function automatic bit modeValid(input logic [2:0] mode);
    return (mode >= 3'd1) && (mode <= 3'd5);
  endfunction

  function automatic int modeN(input logic [2:0] mode);
    case (mode)
      3'd2:       return 16;
      3'd3, 3'd4: return 12;
      default:    return 24;
    endcase
  endfunction

  function automatic int modeW(input logic [2:0] mode);
    return (mode == 3'd5) ? 6 : 4;
  endfunction

  // CRC as the remainder of (seed*x^(N+W) + data*x^W) mod P(x), long division
  function automatic logic [5:0] modelCrc(input logic [2:0] mode, input logic [23:0] data);
    int     n, w;
    longint poly, seed, msg;
    n = modeN(mode);
    w = modeW(mode);
    poly = (w == 4) ? 64'h1D : 64'h59;
    seed = (w == 4) ? 64'h5  : 64'h15;
    msg  = ((seed << n) | (longint'(data) & ((longint'(1) << n) - 1))) << w;
    for (int i = n + 2 * w - 1; i >= w; i--) begin
      if (msg[i]) msg = msg ^ (poly << (i - w));
    end
    return msg[5:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on the same edges the DUT samples
  always @(posedge clk_rx) begin
    if (!reset_n_rx) begin
      mBusy = 1'b0; mDone = 1'b0; mOk = 1'b0; mCalc = 6'd0; mErr = 0; mRem = 0;
    end else begin
      mDone = 1'b0;
      if (mBusy) begin
        mRem--;
        if (mRem == 0) begin
          mDone = 1'b1;
          mBusy = 1'b0;
          mOk   = pendOk;
          mCalc = pendCalc;
          if (!pendOk && mErr < ERR_MAX) mErr++;
        end
      end else if (start_i && modeValid(enable_crc_chk_i)) begin
        mBusy    = 1'b1;
        mRem     = modeN(enable_crc_chk_i) + modeW(enable_crc_chk_i) + 1;
        pendCalc = modelCrc(enable_crc_chk_i, data_chk_crc_i);
        pendOk   = (pendCalc == (crc_rx_i & ((modeW(enable_crc_chk_i) == 6) ? 6'h3F : 6'h0F)));
      end
    end
  end

  // Every cycle, compare all DUT outputs with the model away from the edge
  always @(negedge clk_rx) begin
    if (cmpEn) begin
      checkOutput("cyc_busy", 32'(busy_o), 32'(mBusy));
      checkOutput("cyc_done", 32'(crc_chk_done_o), 32'(mDone));
      checkOutput("cyc_ok", 32'(crc_ok_o), 32'(mOk));
      checkOutput("cyc_calc", 32'(crc_calc_o), 32'(mCalc));
      checkOutput("cyc_errcnt", 32'(crc_err_cnt_o), 32'(mErr));
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic [2:0] mode, input logic [23:0] data, input logic [5:0] crc);
    enable_crc_chk_i = mode;
    data_chk_crc_i   = data;
    crc_rx_i         = crc;
    start_i          = 1'b1;
    @(negedge clk_rx);
    start_i          = 1'b0;
  endtask

  task automatic waitDone(output int cyc, output bit got);
    cyc = 0;
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk_rx);
      cyc++;
      if (crc_chk_done_o === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic runDirected(input string name, input logic [2:0] mode, input logic [23:0] data,
                             input logic [5:0] crc, input int expLat, input bit expOk,
                             input logic [5:0] expCalc, input int expErr);
    int cyc;
    bit got;
    applyStimulus(mode, data, crc);
    waitDone(cyc, got);
    checkOutput({name, "_latency"}, 32'(cyc), 32'(expLat));
    checkOutput({name, "_ok"}, 32'(crc_ok_o), 32'(expOk));
    checkOutput({name, "_calc"}, 32'(crc_calc_o), 32'(expCalc));
    checkOutput({name, "_errcnt"}, 32'(crc_err_cnt_o), 32'(expErr));
  endtask

  initial begin
    int  doneCnt, doneAt, cyc;
    bit  got, activity;
    logic [2:0]  rMode;
    logic [23:0] rData;

    reset_n_rx       = 1'b0;
    start_i          = 1'b0;
    enable_crc_chk_i = 3'd0;
    data_chk_crc_i   = 24'd0;
    crc_rx_i         = 6'd0;
    repeat (3) @(negedge clk_rx);
    reset_n_rx = 1'b1;
    cmpEn      = 1'b1;

    checkOutput("reset_busy", 32'(busy_o), 32'd0);
    checkOutput("reset_done", 32'(crc_chk_done_o), 32'd0);
    checkOutput("reset_ok", 32'(crc_ok_o), 32'd0);
    checkOutput("reset_calc", 32'(crc_calc_o), 32'd0);
    checkOutput("reset_errcnt", 32'(crc_err_cnt_o), 32'd0);

    checkOutput("model_fast4_zero", 32'(modelCrc(3'd2, 24'd0)), 32'h0C);
    checkOutput("model_fast6_zero", 32'(modelCrc(3'd1, 24'd0)), 32'h05);
    checkOutput("model_enh_zero", 32'(modelCrc(3'd5, 24'd0)), 32'h26);
    checkOutput("model_short_zero", 32'(modelCrc(3'd4, 24'd0)), 32'h09);

    runDirected("fast4_pass", 3'd2, 24'h000000, 6'h0C, 21, 1'b1, 6'h0C, 0);
    runDirected("fast6_pass", 3'd1, 24'h000000, 6'h05, 29, 1'b1, 6'h05, 0);
    runDirected("fast6_fail", 3'd1, 24'h000000, 6'h04, 29, 1'b0, 6'h05, 1);
    runDirected("enh_pass",   3'd5, 24'h000000, 6'h26, 31, 1'b1, 6'h26, 1);
    runDirected("short_pass", 3'd4, 24'h000000, 6'h39, 17, 1'b1, 6'h09, 1);

    // Extra starts mid-check and in the CHECK cycle must be ignored
    applyStimulus(3'd2, 24'h000000, 6'h0C);
    doneCnt = 0;
    doneAt  = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_rx);
      if (crc_chk_done_o === 1'b1) begin
        doneCnt++;
        doneAt = c;
      end
      start_i          = (c == 5) || (c == 20);
      enable_crc_chk_i = (c == 5) ? 3'd1 : 3'd5;
      data_chk_crc_i   = 24'($urandom);
      crc_rx_i         = 6'($urandom);
    end
    checkOutput("overlap_done_count", 32'(doneCnt), 32'd1);
    checkOutput("overlap_done_cycle", 32'(doneAt), 32'd21);
    checkOutput("overlap_busy_after", 32'(busy_o), 32'd0);
    checkOutput("overlap_errcnt", 32'(crc_err_cnt_o), 32'd1);

    // Invalid modes never start a check
    activity = 1'b0;
    for (int m = 0; m < 3; m++) begin
      applyStimulus((m == 0) ? 3'd7 : ((m == 1) ? 3'd0 : 3'd6), 24'hABCDEF, 6'h11);
      repeat (4) begin
        @(negedge clk_rx);
        if (busy_o !== 1'b0 || crc_chk_done_o !== 1'b0) activity = 1'b1;
      end
    end
    checkOutput("invalid_mode_activity", 32'(activity), 32'd0);

    // Reset in the middle of a 6-nibble check aborts it silently
    applyStimulus(3'd1, 24'h123456, 6'h03);
    repeat (9) @(negedge clk_rx);
    reset_n_rx = 1'b0;
    @(negedge clk_rx);
    reset_n_rx = 1'b1;
    checkOutput("abort_busy", 32'(busy_o), 32'd0);
    checkOutput("abort_done", 32'(crc_chk_done_o), 32'd0);
    checkOutput("abort_ok", 32'(crc_ok_o), 32'd0);
    checkOutput("abort_calc", 32'(crc_calc_o), 32'd0);
    checkOutput("abort_errcnt", 32'(crc_err_cnt_o), 32'd0);
    doneCnt = 0;
    repeat (40) begin
      @(negedge clk_rx);
      if (crc_chk_done_o === 1'b1) doneCnt++;
    end
    checkOutput("abort_no_done", 32'(doneCnt), 32'd0);
    runDirected("after_abort", 3'd2, 24'h000000, 6'h0C, 21, 1'b1, 6'h0C, 0);

    // Random traffic: modes, data, good/bad CRCs, stray starts, rare resets
    for (int c = 0; c < 3000; c++) begin
      rMode            = 3'($urandom_range(0, 7));
      rData            = 24'($urandom);
      reset_n_rx       = ($urandom_range(0, 299) != 0);
      start_i          = ($urandom_range(0, 5) == 0);
      enable_crc_chk_i = rMode;
      data_chk_crc_i   = rData;
      crc_rx_i         = $urandom_range(0, 1) ? modelCrc(rMode, rData) : 6'($urandom);
      @(negedge clk_rx);
    end
    reset_n_rx = 1'b1;
    start_i    = 1'b0;
    repeat (40) @(negedge clk_rx);
    checkOutput("random_drained_busy", 32'(busy_o), 32'd0);

    // Saturation of the error counter
    reset_n_rx = 1'b0;
    @(negedge clk_rx);
    reset_n_rx = 1'b1;
    for (int k = 1; k <= 260; k++) begin
      rData = 24'($urandom);
      applyStimulus(3'd4, rData, modelCrc(3'd4, rData) ^ 6'h01);
      waitDone(cyc, got);
      if (!got) checkOutput("sat_done_timeout", 32'(got), 32'd1);
      if (k == 10) checkOutput("sat_errcnt_10", 32'(crc_err_cnt_o), 32'd10);
    end
    checkOutput("sat_errcnt_final", 32'(crc_err_cnt_o), 32'(ERR_MAX));
    checkOutput("sat_ok_final", 32'(crc_ok_o), 32'd0);

    repeat (2) @(negedge clk_rx);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
